// File: rtl/seg_scan_scheduler_if.sv
// Display-side bus of the 7-segment scan scheduler: digit data and mask in,
// registered anode/decoder drive out.
interface seg_scan_scheduler_if #(
    parameter int N_DIGITS = 8
) ();
    localparam int IW = $clog2(N_DIGITS);

    logic                  enable;
    logic [4*N_DIGITS-1:0] digits_in;
    logic [N_DIGITS-1:0]   dp_in;
    logic [N_DIGITS-1:0]   digit_mask;
    logic [N_DIGITS-1:0]   anode_n;
    logic [3:0]            bcd_out;
    logic                  dp_out;
    logic [IW-1:0]         digit_idx;
    logic                  slot_tick;

    modport master (
        output enable, digits_in, dp_in, digit_mask,
        input  anode_n, bcd_out, dp_out, digit_idx, slot_tick
    );

    modport slave (
        input  enable, digits_in, dp_in, digit_mask,
        output anode_n, bcd_out, dp_out, digit_idx, slot_tick
    );
endinterface

// File: rtl/seg_scan_scheduler.sv
// Mask-aware time-multiplexing sequencer for an N-digit 7-segment display:
// each enabled digit gets a guard interval (anodes off) followed by its show window.
module seg_scan_scheduler #(
    parameter int N_DIGITS     = 8,
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  reset,
    seg_scan_scheduler_if.slave   bus
);
    localparam int SHOW_CYCLES = SCAN_DIV - BLANK_CYCLES;
    localparam int IW          = $clog2(N_DIGITS);
    localparam int TW          = $clog2(SCAN_DIV);
    localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYCLES - 1);
    localparam logic [TW-1:0] SHOW_LAST  = TW'(SHOW_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    state_t              state_q, state_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [N_DIGITS-1:0] anode_n_q, anode_n_d;
    logic [3:0]          bcd_q, bcd_d;
    logic                dp_q, dp_d;

    // Round-robin search starting after i; falls back to i when no bit is set.
    function automatic logic [IW-1:0] next_set(input logic [IW-1:0] i,
                                               input logic [N_DIGITS-1:0] m);
        logic [IW-1:0] r;
        logic          found;
        int            j;
        r     = i;
        found = 1'b0;
        for (int k = 1; k <= N_DIGITS; k++) begin
            j = (int'(i) + k) % N_DIGITS;
            if (!found && m[j]) begin
                r     = IW'(j);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            idx_q     <= '0;
            anode_n_q <= '1;
            bcd_q     <= '0;
            dp_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            idx_q     <= idx_d;
            anode_n_q <= anode_n_d;
            bcd_q     <= bcd_d;
            dp_q      <= dp_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        idx_d     = idx_q;
        anode_n_d = anode_n_q;
        bcd_d     = bcd_q;
        dp_d      = dp_q;
        if (!bus.enable) begin
            // Decoder outputs hold so a re-enable does not flash a zero digit.
            state_d   = IDLE;
            timer_d   = '0;
            idx_d     = '0;
            anode_n_d = '1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d   = BLANK;
                    timer_d   = '0;
                    idx_d     = '0;
                    anode_n_d = '1;
                end
                BLANK: begin
                    if (timer_q == BLANK_LAST) begin
                        timer_d = '0;
                        if (bus.digit_mask[idx_q]) begin
                            state_d   = SHOW;
                            bcd_d     = bus.digits_in[4*idx_q +: 4];
                            dp_d      = bus.dp_in[idx_q];
                            anode_n_d = ~(N_DIGITS'(1) << idx_q);
                        end else begin
                            idx_d = next_set(idx_q, bus.digit_mask);
                        end
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                SHOW: begin
                    if (timer_q == SHOW_LAST) begin
                        state_d   = BLANK;
                        timer_d   = '0;
                        anode_n_d = '1;
                        idx_d     = next_set(idx_q, bus.digit_mask);
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                default: begin
                    state_d   = IDLE;
                    timer_d   = '0;
                    idx_d     = '0;
                    anode_n_d = '1;
                end
            endcase
        end
    end

    assign bus.anode_n   = anode_n_q;
    assign bus.bcd_out   = bcd_q;
    assign bus.dp_out    = dp_q;
    assign bus.digit_idx = idx_q;
    assign bus.slot_tick = (state_q == SHOW) && (timer_q == SHOW_LAST);
endmodule
